march_sequencer: RTL and testbench
==================================

# march_sequencer

March C- test sequencer for the SRAM BIST. On `start` it drives the SRAM port through the six March C- elements, compares each read against the expected background, and reports pass/fail with the first failing address and element. It sits between the BIST controller (`start`, `done`) and the memory under test, replacing the plain counter sweep with a full read/write march.

## Interface
- `ADDR_W`, default 4: address width; memory depth N = 2**ADDR_W.
- `DATA_W`, default 8: data width; background 0 = all zeros, background 1 = all ones.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin test; sampled only in IDLE.
- `mem_addr`  out  ADDR_W  SRAM address.
- `mem_wdata`  out  DATA_W  SRAM write data.
- `mem_we`  out  1  SRAM write enable.
- `mem_re`  out  1  SRAM read enable.
- `mem_rdata`  in  DATA_W  SRAM read data; valid the cycle after `mem_re`.
- `busy`  out  1  test in progress (RUN or FLUSH).
- `done`  out  1  one-cycle pulse at test end.
- `fail`  out  1  sticky mismatch flag; cleared on accepted `start`.
- `fail_addr`  out  ADDR_W  address of the first mismatch.
- `fail_elem`  out  3  march element (0-5) of the first mismatch.

## Operation
- Elements: M0 up(w0), M1 up(r0,w1), M2 up(r1,w0), M3 down(r0,w1), M4 down(r1,w0), M5 up(r0).
- One op per cycle. Multi-op elements finish both ops at an address before it advances.
- Up order is 0..N-1. Down order is N-1..0. The element advances when the address reaches its terminal value and the last op of the element has been issued.
- Total ops: 10N, split into 5N writes and 5N reads.
- States:
  - IDLE -> RUN when `start`=1.
  - RUN -> FLUSH after the last op (M5, addr N-1).
  - FLUSH -> DONE, always.
  - DONE -> IDLE, always.
- On accepted `start`: clear `fail`, `fail_addr`, `fail_elem`; set element=0, op=0, addr=0.
- Compare: an expected-data/element/address pipeline register is captured with each read. In the following cycle `mem_rdata` is checked against it.
- On the first mismatch, `fail`, `fail_addr` and `fail_elem` are registered. Later mismatches do not overwrite them.
- FLUSH exists only to compare the final read.
- `start` is ignored in RUN, FLUSH and DONE.
- Reset at any point, including mid-RUN: state IDLE, all outputs 0, no write issued in the reset cycle's response.
- When `mem_we` and `mem_re` are both 0, `mem_addr` and `mem_wdata` hold 0.

## Timing
- Reset values: every output 0.
- Take `start`=1 at cycle 0 in IDLE:
  - First op issued in cycle 1.
  - Last op issued in cycle 10N.
  - FLUSH in cycle 10N+1.
  - `done`=1 in cycle 10N+2, then IDLE.
- `busy` is high in cycles 1..10N+1.
- Read issued in cycle t; compared in cycle t+1; `fail` visible in cycle t+2.
- A write issued in the compare cycle completes normally.

## Configuration
- `BIST_STOP_ON_FAIL_EN` defined: a mismatch detected in the compare cycle forces next state DONE. `done` pulses together with `fail`, i.e. 2 cycles after the failing read. Remaining elements are skipped.
- Not defined: the march always runs to completion and failures are only recorded.

## Structure
- Shared package `bist_pkg`:
  - state enum (IDLE, RUN, FLUSH, DONE).
  - march element count constant (6).
  - per-element tables: direction, op count, read background, write background.
  - 3-bit element index type.
- Sub-module `march_addr_gen`: loadable up/down address counter with a terminal-count flag. The sequencer FSM and compare logic stay in `march_sequencer`.

## Test plan
- **Fault-free 16x8 SRAM model, `start` at cycle 0:**
  - 80 writes and 80 reads.
  - `done` at cycle 162, `busy` in cycles 1-161.
  - `fail`=0.
- **Bit 0 stuck-at-0 at address 5, macro off:**
  - `fail`=1, `fail_addr`=5, `fail_elem`=2.
  - `done` still at cycle 162.
  - First-fail values are not overwritten by the M4 mismatch.
- **Same fault, `BIST_STOP_ON_FAIL_EN` defined:**
  - Failing read issued in cycle 59.
  - `fail` and `done` both high in cycle 61, then IDLE.
- **`start` pulsed in cycles 0, 40 and 161:** only the cycle-0 start is accepted; `done` is at cycle 162 only.
- **`rst` asserted in cycle 70 mid-RUN:** all outputs 0 from cycle 71. A new `start` at cycle 75 restarts from M0, addr 0.
- **Down-order check:** in M3 the `mem_addr` sequence is 15,15,14,14,...,0,0, alternating `mem_re`/`mem_we`, with `mem_wdata`=8'hFF on writes.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared types and March C- element tables for the SRAM BIST sequencer.
// Bit i of each table describes march element Mi.
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  typedef logic [2:0] elem_t;

  localparam int ELEMS = 6;

  // M3 and M4 walk the array downward.
  localparam logic [7:0] ELEM_DOWN = 8'b0001_1000;
  // M1..M4 issue a read then a write at each address.
  localparam logic [7:0] ELEM_TWO  = 8'b0001_1110;
  // First op of M1..M5 is a read; M0 is write-only.
  localparam logic [7:0] ELEM_RD   = 8'b0011_1110;
  // Background expected by each element's read.
  localparam logic [7:0] ELEM_RBG  = 8'b0001_0100;
  // Background written by each element's write.
  localparam logic [7:0] ELEM_WBG  = 8'b0000_1010;

  function automatic logic op_is_read(
    input elem_t e,
    input logic  o
  );
    return !o && ELEM_RD[e];
  endfunction

endpackage

// File: rtl/march_addr_gen.sv
// Loadable up/down address counter for the march sequencer.
// last flags the terminal address for the current direction.
module march_addr_gen #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              step,
  input  logic              down,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] nxt,
  output logic              last
);

  localparam logic [ADDR_W-1:0] ONE = 1;

  // Next address: load wins over step, otherwise hold.
  always_comb begin
    nxt = addr;
    if (load)
      nxt = load_val;
    else if (step)
      nxt = down ? addr - ONE : addr + ONE;
  end

  // Address register.
  always_ff @(posedge clk) begin
    if (rst)
      addr <= '0;
    else
      addr <= nxt;
  end

  assign last = down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/march_sequencer.sv
// March C- sequencer: drives the SRAM port, checks reads, reports first fail.
// Optional: define BIST_STOP_ON_FAIL_EN to end the test on the first mismatch.
module march_sequencer
  import bist_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem
);

  state_t state, state_nxt;
  elem_t  elem, elem_nxt, elem_inc;
  logic   op, op_nxt;
  logic   last_op, dir;

  logic              addr_ld, addr_step, addr_last;
  logic [ADDR_W-1:0] addr, addr_nxt, addr_ld_val;

  logic              cmp_valid;
  logic [DATA_W-1:0] cmp_exp;
  logic [ADDR_W-1:0] cmp_addr;
  elem_t             cmp_elem;
  logic              mismatch;

  logic issue, rd_nxt;

  march_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr (
    .clk      (clk),
    .rst      (rst),
    .load     (addr_ld),
    .load_val (addr_ld_val),
    .step     (addr_step),
    .down     (dir),
    .addr     (addr),
    .nxt      (addr_nxt),
    .last     (addr_last)
  );

  assign elem_inc = elem + 3'd1;
  assign dir      = ELEM_DOWN[elem];
  assign last_op  = ELEM_TWO[elem] ? op : 1'b1;
  assign mismatch = cmp_valid && (mem_rdata != cmp_exp);

  // Next march position and next FSM state.
  always_comb begin
    state_nxt   = state;
    elem_nxt    = elem;
    op_nxt      = op;
    addr_ld     = 1'b0;
    addr_ld_val = '0;
    addr_step   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          elem_nxt  = '0;
          op_nxt    = 1'b0;
          addr_ld   = 1'b1;
        end
      end
      RUN: begin
        if (!last_op) begin
          op_nxt = 1'b1;
        end else if (!addr_last) begin
          op_nxt    = 1'b0;
          addr_step = 1'b1;
        end else if (elem == elem_t'(ELEMS - 1)) begin
          state_nxt = FLUSH;
        end else begin
          elem_nxt    = elem_inc;
          op_nxt      = 1'b0;
          addr_ld     = 1'b1;
          addr_ld_val = {ADDR_W{ELEM_DOWN[elem_inc]}};
        end
      end
      FLUSH: state_nxt = DONE;
      DONE:  state_nxt = IDLE;
    endcase
`ifdef BIST_STOP_ON_FAIL_EN
    if (mismatch && (state == RUN || state == FLUSH))
      state_nxt = DONE;
`else
`endif
  end

  // Decode of the op that will be on the port next cycle.
  always_comb begin
    issue  = (state_nxt == RUN);
    rd_nxt = op_is_read(elem_nxt, op_nxt);
  end

  // FSM state, registered port outputs, compare pipe and fail capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      elem      <= '0;
      op        <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
      cmp_valid <= 1'b0;
      cmp_exp   <= '0;
      cmp_addr  <= '0;
      cmp_elem  <= '0;
    end else begin
      state     <= state_nxt;
      elem      <= elem_nxt;
      op        <= op_nxt;
      mem_re    <= issue && rd_nxt;
      mem_we    <= issue && !rd_nxt;
      mem_addr  <= issue ? addr_nxt : '0;
      mem_wdata <= (issue && !rd_nxt) ?
                   {DATA_W{ELEM_WBG[elem_nxt]}} : '0;
      busy      <= (state_nxt == RUN) || (state_nxt == FLUSH);
      done      <= (state_nxt == DONE);
      cmp_valid <= (state == RUN) && mem_re;
      cmp_exp   <= {DATA_W{ELEM_RBG[elem]}};
      cmp_addr  <= mem_addr;
      cmp_elem  <= elem;
      if (state == IDLE && start) begin
        fail      <= 1'b0;
        fail_addr <= '0;
        fail_elem <= '0;
      end else if (mismatch && !fail) begin
        fail      <= 1'b1;
        fail_addr <= cmp_addr;
        fail_elem <= cmp_elem;
      end
    end
  end

endmodule

// File: tb/tb_march_sequencer.sv
// Directed bench for march_sequencer with a 16x8 SRAM model.
// Expectations follow BIST_STOP_ON_FAIL_EN when it is defined.
module tb_march_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] mem_rdata;
  logic       busy;
  logic       done;
  logic       fail;
  logic [3:0] fail_addr;
  logic [2:0] fail_elem;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] mem [16];
  logic       fault_on = 1'b0;

  always #5 clk = ~clk;

  march_sequencer #(
    .ADDR_W(4),
    .DATA_W(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem)
  );

  // SRAM model; optional bit-0 stuck-at-0 cell at address 5.
  always @(posedge clk) begin
    if (mem_we) begin
      if (fault_on && mem_addr == 4'd5)
        mem[mem_addr] <= mem_wdata & 8'hFE;
      else
        mem[mem_addr] <= mem_wdata;
    end
    if (mem_re)
      mem_rdata <= mem[mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if ({mem_we, mem_re, mem_addr, mem_wdata, busy, done,
         fail, fail_addr, fail_elem} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got we=%b re=%b a=%h d=%h b=%b dn=%b f=%b fa=%h fe=%h want all 0",
               mem_we, mem_re, mem_addr, mem_wdata, busy, done,
               fail, fail_addr, fail_elem);
    end
    rst = 1'b0;
    start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy got %b want 0", busy);
    end
  endtask

  task automatic test_fault_free();
    int wr = 0, rd = 0, dn = 0, dcyc = -1;
    int bfirst = -1, blast = -1, bcnt = 0;
    bit first_ok;
    fault_on = 1'b0;
    cyc = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    first_ok = (mem_we === 1'b1) && (mem_addr === 4'd0) &&
               (mem_wdata === 8'h00) && (mem_re === 1'b0);
    checks++;
    if (!first_ok) begin
      errors++;
      $display("FAIL ff_first_op got we=%b re=%b a=%h d=%h want we=1 re=0 a=0 d=00",
               mem_we, mem_re, mem_addr, mem_wdata);
    end
    while (cyc <= 170) begin
      if (mem_we === 1'b1) wr++;
      if (mem_re === 1'b1) rd++;
      if (done === 1'b1) begin
        dn++;
        dcyc = cyc;
      end
      if (busy === 1'b1) begin
        bcnt++;
        if (bfirst < 0) bfirst = cyc;
        blast = cyc;
      end
      tick();
    end
    checks++;
    if (wr != 80) begin
      errors++;
      $display("FAIL ff_writes got %0d want 80", wr);
    end
    checks++;
    if (rd != 80) begin
      errors++;
      $display("FAIL ff_reads got %0d want 80", rd);
    end
    checks++;
    if (dn != 1 || dcyc != 162) begin
      errors++;
      $display("FAIL ff_done got count=%0d cycle=%0d want 1 at 162", dn, dcyc);
    end
    checks++;
    if (bfirst != 1 || blast != 161 || bcnt != 161) begin
      errors++;
      $display("FAIL ff_busy got first=%0d last=%0d n=%0d want 1 161 161",
               bfirst, blast, bcnt);
    end
    checks++;
    if (fail !== 1'b0) begin
      errors++;
      $display("FAIL ff_fail got %b want 0", fail);
    end
  endtask

  task automatic test_down_order();
    logic [3:0] ea;
    bit         is_rd;
    fault_on = 1'b0;
    cyc = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc <= 170) begin
      if (cyc >= 81 && cyc <= 112) begin
        ea    = 4'(15 - (cyc - 81) / 2);
        is_rd = ((cyc - 81) % 2) == 0;
        checks++;
        if (mem_addr !== ea || mem_re !== is_rd || mem_we !== !is_rd ||
            mem_wdata !== (is_rd ? 8'h00 : 8'hFF)) begin
          errors++;
          $display("FAIL m3_seq cyc=%0d got a=%h re=%b we=%b d=%h want a=%h re=%b we=%b d=%h",
                   cyc, mem_addr, mem_re, mem_we, mem_wdata,
                   ea, is_rd, !is_rd, is_rd ? 8'h00 : 8'hFF);
        end
      end
      tick();
    end
  endtask

  task automatic test_stuck_at();
    int dn = 0, dcyc = -1;
    fault_on = 1'b1;
    cyc = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc <= 170) begin
      if (cyc == 59) begin
        checks++;
        if (mem_re !== 1'b1 || mem_addr !== 4'd5) begin
          errors++;
          $display("FAIL sa_read59 got re=%b a=%h want re=1 a=5", mem_re, mem_addr);
        end
      end
      if (cyc == 60) begin
        checks++;
        if (fail !== 1'b0) begin
          errors++;
          $display("FAIL sa_fail60 got %b want 0", fail);
        end
      end
      if (cyc == 61) begin
        checks++;
        if (fail !== 1'b1 || fail_addr !== 4'd5 || fail_elem !== 3'd2) begin
          errors++;
          $display("FAIL sa_fail61 got f=%b fa=%h fe=%h want 1 5 2",
                   fail, fail_addr, fail_elem);
        end
`ifdef BIST_STOP_ON_FAIL_EN
        checks++;
        if (done !== 1'b1 || mem_we !== 1'b0 || mem_re !== 1'b0) begin
          errors++;
          $display("FAIL sa_stop61 got done=%b we=%b re=%b want 1 0 0",
                   done, mem_we, mem_re);
        end
`endif
      end
      if (done === 1'b1) begin
        dn++;
        dcyc = cyc;
      end
      tick();
    end
    checks++;
`ifdef BIST_STOP_ON_FAIL_EN
    if (dn != 1 || dcyc != 61) begin
      errors++;
      $display("FAIL sa_done got count=%0d cycle=%0d want 1 at 61", dn, dcyc);
    end
`else
    if (dn != 1 || dcyc != 162) begin
      errors++;
      $display("FAIL sa_done got count=%0d cycle=%0d want 1 at 162", dn, dcyc);
    end
`endif
    checks++;
    if (fail !== 1'b1 || fail_addr !== 4'd5 || fail_elem !== 3'd2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL sa_final got f=%b fa=%h fe=%h b=%b want 1 5 2 0",
               fail, fail_addr, fail_elem, busy);
    end
  endtask

  task automatic test_start_ignored();
    int dn = 0, dcyc = -1;
    fault_on = 1'b0;
    cyc = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc <= 175) begin
      start = (cyc == 40 || cyc == 161);
      if (done === 1'b1) begin
        dn++;
        dcyc = cyc;
      end
      tick();
    end
    start = 1'b0;
    checks++;
    if (dn != 1 || dcyc != 162) begin
      errors++;
      $display("FAIL start_ign_done got count=%0d cycle=%0d want 1 at 162", dn, dcyc);
    end
    checks++;
    if (busy !== 1'b0 || fail !== 1'b0) begin
      errors++;
      $display("FAIL start_ign_idle got busy=%b fail=%b want 0 0", busy, fail);
    end
  endtask

  task automatic test_reset_mid_run();
    int dcyc = -1;
    fault_on = 1'b1;
    cyc = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc <= 260) begin
      rst   = (cyc == 70);
      start = (cyc == 75);
      if (cyc == 69) begin
        checks++;
`ifdef BIST_STOP_ON_FAIL_EN
        if (fail !== 1'b1 || busy !== 1'b0) begin
          errors++;
          $display("FAIL rst_pre got fail=%b busy=%b want 1 0", fail, busy);
        end
`else
        if (fail !== 1'b1 || busy !== 1'b1) begin
          errors++;
          $display("FAIL rst_pre got fail=%b busy=%b want 1 1", fail, busy);
        end
`endif
      end
      if (cyc == 71) begin
        checks++;
        if ({mem_we, mem_re, mem_addr, mem_wdata, busy, done,
             fail, fail_addr, fail_elem} !== '0) begin
          errors++;
          $display("FAIL rst_mid_outputs got we=%b re=%b a=%h d=%h b=%b dn=%b f=%b fa=%h fe=%h want all 0",
                   mem_we, mem_re, mem_addr, mem_wdata, busy, done,
                   fail, fail_addr, fail_elem);
        end
      end
      if (cyc == 74) begin
        checks++;
        if (busy !== 1'b0 || mem_we !== 1'b0) begin
          errors++;
          $display("FAIL rst_idle74 got busy=%b we=%b want 0 0", busy, mem_we);
        end
      end
      if (cyc == 76) begin
        checks++;
        if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_addr !== 4'd0 ||
            mem_wdata !== 8'h00 || busy !== 1'b1) begin
          errors++;
          $display("FAIL rst_restart got we=%b re=%b a=%h d=%h b=%b want 1 0 0 00 1",
                   mem_we, mem_re, mem_addr, mem_wdata, busy);
        end
      end
      if (cyc == 77) begin
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 4'd1) begin
          errors++;
          $display("FAIL rst_restart2 got we=%b a=%h want 1 1", mem_we, mem_addr);
        end
      end
      if (done === 1'b1 && dcyc < 0) dcyc = cyc;
      tick();
    end
    rst = 1'b0;
    start = 1'b0;
    checks++;
`ifdef BIST_STOP_ON_FAIL_EN
    if (dcyc != 136) begin
      errors++;
      $display("FAIL rst_done got %0d want 136", dcyc);
    end
`else
    if (dcyc != 237) begin
      errors++;
      $display("FAIL rst_done got %0d want 237", dcyc);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_fault_free();
    test_down_order();
    test_stuck_at();
    test_start_ignored();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
